cmp_share_arbiter: RTL and testbench
====================================

// Module: cmp_share_arbiter
// PURPOSE
//   Shares one signed/unsigned magnitude comparator (Greater/Equal/Less) between
//   NUM_REQ requesters (e.g. branch unit, SLT/SLTU path, encryption accelerator).
//   Round-robin grant; operands latched on accept; flags registered and returned
//   to the granted requester over a valid/ready response handshake.
// PARAMETERS
//   DATA_WIDTH  32  operand width in bits
//   NUM_REQ     3   number of requesters (>=2); GW = $clog2(NUM_REQ)
// PORTS
//   clk           in   1                  clock, all state on rising edge
//   rst           in   1                  synchronous, active-high reset
//   req_valid     in   NUM_REQ            per-requester compare request
//   req_ready     out  NUM_REQ            one-hot accept strobe
//   req_op_a      in   NUM_REQ*DATA_WIDTH packed operand A; requester i at [i*DW +: DW]
//   req_op_b      in   NUM_REQ*DATA_WIDTH packed operand B, same packing
//   req_unsigned  in   NUM_REQ            1 = unsigned compare, 0 = two's-complement
//   rsp_valid     out  NUM_REQ            one-hot: result ready for requester i
//   rsp_ready     in   NUM_REQ            requester i consumes result
//   rsp_greater   out  1                  A > B  (qualified by |rsp_valid)
//   rsp_equal     out  1                  A == B
//   rsp_less      out  1                  A < B
//   rsp_grant     out  GW                 index of requester owning the response
//   busy          out  1                  high in any state other than IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, ptr=NUM_REQ-1 (requester 0 wins first), req_ready=0,
//     rsp_valid=0, rsp_greater/equal/less=0, rsp_grant=0, busy=0, operand regs=0.
//   - FSM IDLE -> CMP -> RESP -> IDLE.
//   - IDLE: if |req_valid, g = first i with req_valid[i] searching ptr+1, ptr+2, ...
//     modulo NUM_REQ; req_ready[g]=1 this cycle (combinational, only in IDLE);
//     latch op_a, op_b, unsigned flag, g; go CMP. No request -> stay IDLE.
//   - CMP: evaluate on latched operands; exactly one of G/E/L set; register flags;
//     go RESP. Signed: A,B as two's-complement; unsigned: as naturals.
//   - RESP: rsp_valid[g]=1, flags and rsp_grant stable; leave to IDLE on the cycle
//     rsp_ready[g]=1; ptr<=g at that edge. rsp_ready of other requesters ignored.
//   - Latency: accept edge T -> rsp_valid high from T+2; min 3 cycles per compare
//     (no back-to-back accept while busy; req_ready=0 in CMP/RESP).
//   - Requests are level: a requester holds req_valid/operands until req_ready;
//     deasserting req_valid after accept has no effect on the in-flight compare.
//   - Operand changes on req_op_* after accept do not affect the result.
//   - Simultaneous requests: exactly one grant per IDLE cycle, strict rotation.
//   - rsp_ready asserted in same cycle rsp_valid rises: completes that cycle.
//   - Reset mid-operation (CMP or RESP): compare abandoned, no response issued,
//     all outputs to reset values next cycle.
//   - Flags are 0 whenever rsp_valid==0.
// TESTING
//   1. rst high 2 cycles, valid[0]=1 A=5 B=3 signed -> ready[0] cycle 0,
//      rsp_valid[0] at +2: G=1 E=0 L=0, grant=0.
//   2. Signed vs unsigned: A=32'hFFFF_FD71(-655) B=3: signed -> L=1;
//      unsigned -> G=1; A=B=-11 -> E=1 both modes.
//   3. All three valid continuously, rsp_ready always 1 -> grant order 0,1,2,0,
//      one accept every 3 cycles, no starvation.
//   4. rsp_ready[g]=0 for 5 cycles in RESP -> rsp_valid/flags held, req_ready all 0,
//      others waiting; release -> next grant follows rotation.
//   5. Assert rst during CMP (A=255 B=-343) -> no rsp_valid ever for that request,
//      state IDLE, requester 0 granted first after reset.
//   6. Random 1000 requests, random modes/backpressure -> flags match golden
//      $signed/unsigned compare, exactly one flag set per response.

Source files
------------

// File: rtl/cmp_share_arbiter.sv
// Round-robin shared magnitude comparator: one accept per IDLE visit, operands
// latched on accept, registered G/E/L returned over a per-requester valid/ready.
module cmp_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 3,
    parameter int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_op_b,
    input  logic [NUM_REQ-1:0]            req_unsigned,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic                          rsp_greater,
    output logic                          rsp_equal,
    output logic                          rsp_less,
    output logic [GW-1:0]                 rsp_grant,
    output logic                          busy
);

    // state | meaning
    // IDLE  | waiting for a request; grants combinationally
    // CMP   | comparing latched operands
    // RESP  | result presented to the granted requester
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         ptr_q, ptr_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic                  uns_q, uns_d;
    logic                  gt_q, gt_d;
    logic                  eq_q, eq_d;
    logic                  lt_q, lt_d;

    logic                  pick_found;
    logic [GW-1:0]         pick_idx;
    logic [GW-1:0]         cand;
    logic                  cmp_eq;
    logic                  cmp_lt;

    // Search starts just after the last served requester.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(ptr_q) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        cmp_eq = (op_a_q == op_b_q);
        if (uns_q) begin
            cmp_lt = (op_a_q < op_b_q);
        end else begin
            cmp_lt = ($signed(op_a_q) < $signed(op_b_q));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= GW'(NUM_REQ - 1);
            grant_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            uns_q   <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            uns_q   <= uns_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_found) state_d = CMP;
            CMP:     state_d = RESP;
            RESP:    if (rsp_ready[grant_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        grant_d = grant_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        uns_d   = uns_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        if (state_q == IDLE && pick_found) begin
            grant_d = pick_idx;
            op_a_d  = req_op_a[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            op_b_d  = req_op_b[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            uns_d   = req_unsigned[pick_idx];
        end
        if (state_q == CMP) begin
            eq_d = cmp_eq;
            lt_d = cmp_lt;
            gt_d = !cmp_eq && !cmp_lt;
        end
        if (state_q == RESP && rsp_ready[grant_q]) begin
            ptr_d = grant_q;
        end
    end

    always_comb begin
        req_ready   = '0;
        rsp_valid   = '0;
        rsp_greater = 1'b0;
        rsp_equal   = 1'b0;
        rsp_less    = 1'b0;
        rsp_grant   = grant_q;
        busy        = (state_q != IDLE);
        if (state_q == IDLE && pick_found) begin
            req_ready[pick_idx] = 1'b1;
        end
        if (state_q == RESP) begin
            rsp_valid[grant_q] = 1'b1;
            rsp_greater        = gt_q;
            rsp_equal          = eq_q;
            rsp_less           = lt_q;
        end
    end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Directed and random bench for cmp_share_arbiter with an accept-time scoreboard
// and a cycle model of grant rotation and response timing.
module tb_cmp_share_arbiter;

    localparam int DW = 32;
    localparam int NR = 3;
    localparam int GW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_op_a;
    logic [NR*DW-1:0]  req_op_b;
    logic [NR-1:0]     req_unsigned;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready;
    logic              rsp_greater;
    logic              rsp_equal;
    logic              rsp_less;
    logic [GW-1:0]     rsp_grant;
    logic              busy;

    always #5 clk = ~clk;

    cmp_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .GW(GW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_a(req_op_a), .req_op_b(req_op_b), .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_greater(rsp_greater), .rsp_equal(rsp_equal), .rsp_less(rsp_less),
        .rsp_grant(rsp_grant), .busy(busy)
    );

    typedef struct {
        int   idx;
        logic g;
        logic e;
        logic l;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_log[$];
    int          acc_cyc[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          mst = 0;
    int          mptr = NR - 1;
    int          mgrant = 0;
    int          cycle = 0;
    int          n_rsp = 0;
    int          last_rsp_cyc = 0;
    logic [2:0]  last_flags = '0;
    logic        keep_valid = 1'b0;
    logic [NR-1:0] acc = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t golden(input int i);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        exp_t          r;
        a     = req_op_a[i*DW +: DW];
        b     = req_op_b[i*DW +: DW];
        r.idx = i;
        r.e   = (a == b);
        if (req_unsigned[i]) begin
            r.g = (a > b);
            r.l = (a < b);
        end else begin
            r.g = ($signed(a) > $signed(b));
            r.l = ($signed(a) < $signed(b));
        end
        return r;
    endfunction

    task automatic rnd_ops(input int i);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            x;
        case ($urandom_range(0, 3))
            0: begin a = $urandom; b = $urandom; end
            1: begin a = $urandom; b = a; end
            2: begin
                x = $urandom_range(0, 7) - 4; a = 32'(x);
                x = $urandom_range(0, 7) - 4; b = 32'(x);
            end
            default: begin a = {1'b1, 31'($urandom)}; b = {1'b0, 31'($urandom)}; end
        endcase
        if ($urandom_range(0, 1) == 1) begin
            req_op_a[i*DW +: DW] = a;
            req_op_b[i*DW +: DW] = b;
        end else begin
            req_op_a[i*DW +: DW] = b;
            req_op_b[i*DW +: DW] = a;
        end
        req_unsigned[i] = 1'($urandom_range(0, 1));
    endtask

    // Sampled on the falling edge: predicts what the next rising edge commits.
    task automatic monitor();
        logic [NR-1:0] exp_rdy;
        int            nxt;
        int            gsel;
        exp_t          e;
        exp_rdy = '0;
        nxt     = mst;
        gsel    = -1;
        acc     = '0;
        if (mst == 0 && req_valid != '0) begin
            for (int k = 1; k <= NR; k++) begin
                if (gsel < 0 && req_valid[(mptr + k) % NR]) gsel = (mptr + k) % NR;
            end
            exp_rdy[gsel] = 1'b1;
        end
        check("req_ready", req_ready, exp_rdy);
        check("busy", busy, (mst != 0));
        if (gsel >= 0) begin
            exp_q.push_back(golden(gsel));
            mgrant = gsel;
            acc_log.push_back(gsel);
            acc_cyc.push_back(cycle);
            acc = exp_rdy;
            nxt = 1;
        end
        if (mst == 1) nxt = 2;
        if (mst == 2) begin
            check("rsp_valid", rsp_valid, (1 << mgrant));
            check("rsp_grant", rsp_grant, mgrant);
            check("sb_depth", exp_q.size(), 1);
            check("one_flag", int'(rsp_greater) + int'(rsp_equal) + int'(rsp_less), 1);
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                check("flags_gel", {rsp_greater, rsp_equal, rsp_less}, {e.g, e.e, e.l});
                if (rsp_ready[mgrant]) begin
                    void'(exp_q.pop_front());
                    mptr         = mgrant;
                    nxt          = 0;
                    n_rsp++;
                    last_rsp_cyc = cycle;
                    last_flags   = {rsp_greater, rsp_equal, rsp_less};
                end
            end
        end else begin
            check("rsp_quiet", {rsp_valid, rsp_greater, rsp_equal, rsp_less}, 0);
        end
        mst = nxt;
        if (rst) begin
            mst  = 0;
            mptr = NR - 1;
            exp_q.delete();
        end
    endtask

    // One clock: sample, advance, then retire accepted requests (and scramble
    // their operands so a missed latch shows up as a flag error).
    task automatic cyc();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cycle++;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                rnd_ops(i);
                if (!keep_valid) req_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic run_one(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic u, input logic [2:0] exp3, input string tag);
        int start;
        req_op_a[i*DW +: DW] = a;
        req_op_b[i*DW +: DW] = b;
        req_unsigned[i]      = u;
        req_valid[i]         = 1'b1;
        start                = n_rsp;
        for (int t = 0; t < 20 && n_rsp == start; t++) cyc();
        check({tag, "_done"}, n_rsp, start + 1);
        check(tag, last_flags, exp3);
    endtask

    task automatic drain();
        for (int t = 0; t < 40 && (req_valid != '0 || mst != 0); t++) cyc();
        check("drain_idle", busy, 0);
    endtask

    initial begin
        int n0;
        int g0;
        int start;
        rst          = 1'b1;
        req_valid    = '0;
        req_op_a     = '0;
        req_op_b     = '0;
        req_unsigned = '0;
        rsp_ready    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_flags", {rsp_greater, rsp_equal, rsp_less}, 0);
        check("rst_grant", rsp_grant, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // basic signed compare with latency check
        rsp_ready = '1;
        run_one(0, 32'd5, 32'd3, 1'b0, 3'b100, "t1_gt");
        check("t1_grant", acc_log[$], 0);
        check("t1_latency", last_rsp_cyc - acc_cyc[$], 2);

        // signed versus unsigned interpretation
        run_one(1, 32'hFFFF_FD71, 32'd3, 1'b0, 3'b001, "t2_s_lt");
        run_one(1, 32'hFFFF_FD71, 32'd3, 1'b1, 3'b100, "t2_u_gt");
        run_one(2, 32'hFFFF_FFF5, 32'hFFFF_FFF5, 1'b0, 3'b010, "t2_s_eq");
        run_one(2, 32'hFFFF_FFF5, 32'hFFFF_FFF5, 1'b1, 3'b010, "t2_u_eq");

        // all requesters continuously valid: strict rotation, 3-cycle spacing
        keep_valid = 1'b1;
        for (int i = 0; i < NR; i++) rnd_ops(i);
        req_valid = '1;
        n0 = acc_log.size();
        for (int t = 0; t < 30 && acc_log.size() < n0 + 4; t++) cyc();
        check("t3_accepts", acc_log.size() >= n0 + 4, 1);
        if (acc_log.size() >= n0 + 4) begin
            check("t3_order0", acc_log[n0],     0);
            check("t3_order1", acc_log[n0 + 1], 1);
            check("t3_order2", acc_log[n0 + 2], 2);
            check("t3_order3", acc_log[n0 + 3], 0);
            check("t3_gap1", acc_cyc[n0 + 1] - acc_cyc[n0],     3);
            check("t3_gap3", acc_cyc[n0 + 3] - acc_cyc[n0 + 2], 3);
        end
        keep_valid = 1'b0;
        req_valid  = '0;
        drain();

        // response backpressure
        keep_valid = 1'b1;
        rsp_ready  = '0;
        req_valid  = '1;
        for (int t = 0; t < 10 && mst != 2; t++) cyc();
        g0 = mgrant;
        repeat (5) cyc();
        check("t4_hold_valid", rsp_valid, (1 << g0));
        check("t4_hold_ready", req_ready, 0);
        rsp_ready = '1;
        n0 = acc_log.size();
        for (int t = 0; t < 10 && acc_log.size() <= n0; t++) cyc();
        check("t4_accept", acc_log.size(), n0 + 1);
        if (acc_log.size() > n0) check("t4_next_grant", acc_log[n0], (g0 + 1) % NR);
        keep_valid = 1'b0;
        req_valid  = '0;
        drain();

        // reset during CMP abandons the compare and restores rotation
        run_one(0, 32'd1, 32'd1, 1'b1, 3'b010, "t5_pre");
        req_op_a[1*DW +: DW] = 32'd255;
        req_op_b[1*DW +: DW] = 32'hFFFF_FEA9;
        req_unsigned[1]      = 1'b0;
        req_valid[1]         = 1'b1;
        start = n_rsp;
        n0    = acc_log.size();
        for (int t = 0; t < 10 && acc_log.size() == n0; t++) cyc();
        check("t5_accept", acc_log.size(), n0 + 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (4) cyc();
        check("t5_no_rsp", n_rsp, start);
        check("t5_idle", busy, 0);
        req_valid = '1;
        for (int i = 0; i < NR; i++) rnd_ops(i);
        cyc();
        check("t5_first_grant", acc_log[$], 0);
        drain();

        // random traffic with random backpressure
        start = n_rsp;
        for (int t = 0; t < 20000 && n_rsp < start + 1000; t++) begin
            rsp_ready = NR'($urandom);
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    rnd_ops(i);
                    req_valid[i] = 1'b1;
                end
            end
            cyc();
        end
        check("t6_count", n_rsp - start >= 1000, 1);
        req_valid = '0;
        rsp_ready = '1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
